// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  typedef enum logic {
    StClear = 1'b0,
    StReady = 1'b1
  } seq_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: sweeps every writable entry to zero, then
// parks in StReady until the next reset.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] StartPtr = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LastPtr  = '1;

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == StClear) begin
      // Terminate on compare so the pointer never relies on wrapping.
      if (clr_ptr_q == LastPtr) begin
        state_d = StReady;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_ptr_q <= StartPtr;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign clr_we    = (state_q == StClear);
  assign clr_addr  = clr_ptr_q;
  assign init_done = (state_q == StReady);

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NUM_RD-read register file with combinational reads, same-cycle
// write-to-read bypass and a post-reset clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb0_en,
  input  logic [ADDR_W-1:0]        wb0_addr,
  input  logic [DATA_W-1:0]        wb0_data,
  input  logic                     wb1_en,
  input  logic [ADDR_W-1:0]        wb1_addr,
  input  logic [DATA_W-1:0]        wb1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     init_done
);

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam bit          ZeroHw = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [Depth];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              we0, we1;

  regfile_clr_seq #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  // Writes to the hardwired-zero entry are dropped here so bypass never sees them.
  assign we0 = init_done && wb0_en && !(ZeroHw && (wb0_addr == '0));
  assign we1 = init_done && wb1_en && !(ZeroHw && (wb1_addr == '0));

  // Port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (we0) mem_q[wb0_addr] <= wb0_data;
      if (we1) mem_q[wb1_addr] <= wb1_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem_q[addr];
      if (we0 && (wb0_addr == addr)) data = wb0_data;
      if (we1 && (wb1_addr == addr)) data = wb1_data;
      if (!init_done || (ZeroHw && (addr == '0))) data = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default instance and a
// ZERO_REG=0 / ADDR_W=3 / NUM_RD=3 instance, both against an array model.
module tb_regfile_mp;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s [NI];
  logic        w0e   [NI];
  logic        w1e   [NI];
  logic [4:0]  w0a   [NI];
  logic [4:0]  w1a   [NI];
  logic [31:0] w0d   [NI];
  logic [31:0] w1d   [NI];
  logic [4:0]  ra    [NI][4];

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic        a_init_done;
  logic [8:0]  b_rd_addr;
  logic [95:0] b_rd_data;
  logic        b_init_done;

  assign a_rd_addr = {ra[0][1], ra[0][0]};
  assign b_rd_addr = {ra[1][2][2:0], ra[1][1][2:0], ra[1][0][2:0]};

  regfile_mp u_dut_a (
    .clk       (clk),
    .rst       (rst_s[0]),
    .wb0_en    (w0e[0]),
    .wb0_addr  (w0a[0]),
    .wb0_data  (w0d[0]),
    .wb1_en    (w1e[0]),
    .wb1_addr  (w1a[0]),
    .wb1_data  (w1d[0]),
    .rd_addr   (a_rd_addr),
    .rd_data   (a_rd_data),
    .init_done (a_init_done)
  );

  regfile_mp #(
    .DATA_W   (32),
    .ADDR_W   (3),
    .NUM_RD   (3),
    .ZERO_REG (0)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst_s[1]),
    .wb0_en    (w0e[1]),
    .wb0_addr  (w0a[1][2:0]),
    .wb0_data  (w0d[1]),
    .wb1_en    (w1e[1]),
    .wb1_addr  (w1a[1][2:0]),
    .wb1_data  (w1d[1]),
    .rd_addr   (b_rd_addr),
    .rd_data   (b_rd_data),
    .init_done (b_init_done)
  );

  // Reference model: contents, readiness, remaining sweep cycles.
  logic [31:0] mdl   [NI][32];
  bit          rdy   [NI];
  int          cnt   [NI];
  int          depth [NI] = '{32, 8};
  int          zr    [NI] = '{1, 0};
  int          nrd   [NI] = '{2, 3};

  typedef struct {
    int          inst;
    int          port;   // -1 selects init_done
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t  sbq[$];
  int    errors = 0;
  int    checks = 0;
  string phase  = "reset";

  function automatic logic [31:0] exp_rd(int i, logic [4:0] a);
    if (!rdy[i]) return 32'h0;
    if (zr[i] != 0 && a == 5'd0) return 32'h0;
    if (w1e[i] && w1a[i] == a) return w1d[i];
    if (w0e[i] && w0a[i] == a) return w0d[i];
    return mdl[i][a];
  endfunction

  task automatic chk(logic [31:0] act, logic [31:0] exp, string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_expects();
    for (int i = 0; i < NI; i++) begin
      sbq.push_back('{inst: i, port: -1, exp: {31'd0, rdy[i]}, name: phase});
      for (int p = 0; p < nrd[i]; p++)
        sbq.push_back('{inst: i, port: p, exp: exp_rd(i, ra[i][p]), name: phase});
    end
  endtask

  task automatic advance();
    for (int i = 0; i < NI; i++) begin
      if (rst_s[i]) begin
        rdy[i] = 1'b0;
        cnt[i] = depth[i] - zr[i];
      end else if (!rdy[i]) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          rdy[i] = 1'b1;
          for (int a = 0; a < 32; a++) mdl[i][a] = 32'h0;
        end
      end else begin
        if (w0e[i] && !(zr[i] != 0 && w0a[i] == 5'd0)) mdl[i][w0a[i]] = w0d[i];
        if (w1e[i] && !(zr[i] != 0 && w1a[i] == 5'd0)) mdl[i][w1a[i]] = w1d[i];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    push_expects();
    advance();
  endtask

  task automatic idle(int i);
    rst_s[i] = 1'b0;
    w0e[i]   = 1'b0;
    w1e[i]   = 1'b0;
    for (int p = 0; p < 4; p++) ra[i][p] = 5'($urandom_range(0, depth[i] - 1));
  endtask

  task automatic rnd(int i);
    rst_s[i] = 1'b0;
    w0e[i]   = 1'($urandom_range(0, 1));
    w1e[i]   = 1'($urandom_range(0, 1));
    w0a[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, depth[i] - 1));
    w1a[i]   = ($urandom_range(0, 3) == 0) ? w0a[i] : 5'($urandom_range(0, depth[i] - 1));
    w0d[i]   = $urandom;
    w1d[i]   = $urandom;
    for (int p = 0; p < 4; p++) begin
      case ($urandom_range(0, 3))
        0:       ra[i][p] = w0a[i];
        1:       ra[i][p] = w1a[i];
        default: ra[i][p] = 5'($urandom_range(0, depth[i] - 1));
      endcase
    end
  endtask

  task automatic readback(int i, string nm);
    phase = nm;
    for (int a = 0; a < depth[i]; a += nrd[i]) begin
      idle(0);
      idle(1);
      for (int p = 0; p < nrd[i]; p++) ra[i][p] = 5'((a + p) % depth[i]);
      cyc();
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sbq.pop_front();
      if (e.port < 0) act = {31'd0, (e.inst == 0) ? a_init_done : b_init_done};
      else if (e.inst == 0) act = a_rd_data[e.port*32 +: 32];
      else act = b_rd_data[e.port*32 +: 32];
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s inst%0d port%0d: got %h expected %h", e.name, e.inst, e.port,
                 act, e.exp);
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      idle(i);
      rst_s[i] = 1'b1;
      w0a[i]   = 5'd0;
      w1a[i]   = 5'd0;
      w0d[i]   = 32'h0;
      w1d[i]   = 32'h0;
      rdy[i]   = 1'b0;
      cnt[i]   = 0;
    end
    advance();
    chk({31'd0, a_init_done}, 32'd0, "reset_init_done_a");
    chk({31'd0, b_init_done}, 32'd0, "reset_init_done_b");
    chk(a_rd_data[31:0], 32'd0, "reset_rd_data_a");

    // Sweep with ignored writes, then reset again at sweep cycle 10.
    phase = "sweep_a";
    for (int c = 0; c < 10; c++) begin rnd(0); rnd(1); cyc(); end
    phase = "rst_mid_sweep";
    rnd(0); rnd(1); rst_s[0] = 1'b1; cyc();
    chk({31'd0, a_init_done}, 32'd0, "rst_mid_sweep_init_done");
    phase = "sweep_a2";
    for (int c = 0; c < 30; c++) begin rnd(0); idle(1); cyc(); end
    chk({31'd0, a_init_done}, 32'd0, "init_done_early_a");
    rnd(0); idle(1); cyc();
    chk({31'd0, a_init_done}, 32'd1, "init_done_wait_expired_a");
    readback(0, "clear_a");

    phase = "bypass_5";
    idle(0); idle(1);
    w0e[0] = 1'b1; w0a[0] = 5'd5; w0d[0] = 32'hDEADBEEF; ra[0][0] = 5'd5;
    cyc();
    phase = "stored_5";
    idle(0); ra[0][0] = 5'd5; #1;
    chk(a_rd_data[31:0], 32'hDEADBEEF, "stored_5_direct");
    cyc();

    phase = "collide_7";
    idle(0);
    w0e[0] = 1'b1; w0a[0] = 5'd7; w0d[0] = 32'h11111111;
    w1e[0] = 1'b1; w1a[0] = 5'd7; w1d[0] = 32'h22222222;
    ra[0][0] = 5'd7; ra[0][1] = 5'd7;
    cyc();
    phase = "stored_7";
    idle(0); ra[0][1] = 5'd7; #1;
    chk(a_rd_data[63:32], 32'h22222222, "stored_7_direct");
    cyc();

    phase = "zero_wr";
    idle(0);
    w1e[0] = 1'b1; w1a[0] = 5'd0; w1d[0] = 32'hFFFFFFFF;
    ra[0][0] = 5'd0; ra[0][1] = 5'd0;
    cyc();
    phase = "zero_after";
    idle(0); ra[0][0] = 5'd0; ra[0][1] = 5'd0; cyc();

    // ZERO_REG=0 instance: fresh 8-cycle sweep, then address 0 is writable.
    phase = "sweep_b";
    idle(0); idle(1); rst_s[1] = 1'b1; cyc();
    for (int c = 0; c < 8; c++) begin idle(0); rnd(1); cyc(); end
    chk({31'd0, b_init_done}, 32'd1, "init_done_wait_expired_b");
    phase = "b_wr";
    idle(1);
    w0e[1] = 1'b1; w0a[1] = 5'd0; w0d[1] = 32'hA5A5A5A5;
    w1e[1] = 1'b1; w1a[1] = 5'd3; w1d[1] = 32'h3C3C3C3C;
    ra[1][0] = 5'd0; ra[1][1] = 5'd3; ra[1][2] = 5'd6;
    cyc();
    phase = "b_rd3";
    idle(1); ra[1][0] = 5'd3; ra[1][1] = 5'd0; ra[1][2] = 5'd7; cyc();

    phase = "random";
    for (int c = 0; c < 400; c++) begin
      rnd(0);
      rnd(1);
      if ($urandom_range(0, 63) == 0) rst_s[1] = 1'b1;
      cyc();
    end

    // Reset from READY must re-clear everything before init_done returns.
    phase = "rst_ready";
    rnd(0); rnd(1); rst_s[0] = 1'b1; cyc();
    chk({31'd0, a_init_done}, 32'd0, "rst_ready_init_done");
    phase = "sweep_a3";
    for (int c = 0; c < 31; c++) begin rnd(0); rnd(1); cyc(); end
    chk({31'd0, a_init_done}, 32'd1, "init_done_wait_expired_a3");
    readback(0, "clear_a3");
    readback(1, "final_b");

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
